// File: rtl/snow64_direct_mapped_instr_cache_if.sv
// Fetch/memory bus of the direct-mapped instruction cache.
//   master : the environment (fetch stage and memory arbiter); drives the
//            read request, invalidate and fill response, and observes the rest
//   slave  : the cache itself
// Signals:
//   in_req_read_req / in_req_read_addr  fetch request and byte address
//   in_invalidate                       drop every cached line
//   out_req_read_valid / _instr         fetched instruction, one-cycle strobe
//   out_mem_access_req / _addr          one-cycle line fill request
//   in_mem_access_valid / _data         fill response carrying a whole line
interface snow64_direct_mapped_instr_cache_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_WIDTH  = 256
);
  logic                   in_req_read_req;
  logic [ADDR_WIDTH-1:0]  in_req_read_addr;
  logic                   in_invalidate;
  logic                   out_req_read_valid;
  logic [INSTR_WIDTH-1:0] out_req_read_instr;
  logic                   out_mem_access_req;
  logic [ADDR_WIDTH-1:0]  out_mem_access_addr;
  logic                   in_mem_access_valid;
  logic [LINE_WIDTH-1:0]  in_mem_access_data;

  modport master (
    output in_req_read_req, in_req_read_addr, in_invalidate,
           in_mem_access_valid, in_mem_access_data,
    input  out_req_read_valid, out_req_read_instr,
           out_mem_access_req, out_mem_access_addr
  );

  modport slave (
    input  in_req_read_req, in_req_read_addr, in_invalidate,
           in_mem_access_valid, in_mem_access_data,
    output out_req_read_valid, out_req_read_instr,
           out_mem_access_req, out_mem_access_addr
  );
endinterface

// File: rtl/snow64_direct_mapped_instr_cache.sv
// Direct-mapped, read-only instruction cache between fetch and memory arbiter.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of snow64_direct_mapped_instr_cache_if (fetch request,
//           instruction return, whole-cache invalidate, line fill handshake)
// Hits return the instruction one cycle after the request. A miss emits a
// single-cycle fill request for the line-aligned address and waits for the
// fill, which is forwarded to the requester and written into the line.
module snow64_direct_mapped_instr_cache #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int NUM_LINES   = 8
) (
  input logic clk,
  input logic rst_n,
  snow64_direct_mapped_instr_cache_if.slave bus
);
  localparam int WORDS     = LINE_WIDTH / INSTR_WIDTH;
  localparam int BYTE_BITS = $clog2(INSTR_WIDTH / 8);
  localparam int OFF_BITS  = $clog2(WORDS);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - OFF_BITS - BYTE_BITS;

  typedef enum logic {IDLE, WAIT_FOR_MEM} state_t;
  typedef logic [WORDS-1:0][INSTR_WIDTH-1:0] line_t;

  state_t                 state, state_nxt;
  logic [NUM_LINES-1:0]   valid, valid_nxt;
  logic                   pend_inv, pend_inv_nxt;
  logic                   out_valid, out_valid_nxt;
  logic [INSTR_WIDTH-1:0] out_instr, out_instr_nxt;
  logic                   mem_req, mem_req_nxt;
  logic [ADDR_WIDTH-1:0]  mem_addr, mem_addr_nxt;
  logic                   capture, fill_write;

  line_t                  data_arr [NUM_LINES];
  logic [TAG_BITS-1:0]    tag_arr  [NUM_LINES];
  logic [TAG_BITS-1:0]    cap_tag;
  logic [IDX_BITS-1:0]    cap_idx;
  logic [OFF_BITS-1:0]    cap_off;

  logic [TAG_BITS-1:0]    req_tag;
  logic [IDX_BITS-1:0]    req_idx;
  logic [OFF_BITS-1:0]    req_off;
  logic                   unused_byte_bits;
  line_t                  fill_line;
  logic                   hit;

  assign req_tag          = bus.in_req_read_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_idx          = bus.in_req_read_addr[BYTE_BITS+OFF_BITS +: IDX_BITS];
  assign req_off          = bus.in_req_read_addr[BYTE_BITS +: OFF_BITS];
  assign unused_byte_bits = ^bus.in_req_read_addr[BYTE_BITS-1:0];
  assign fill_line        = bus.in_mem_access_data;

  // A same-cycle invalidate wins over the lookup, so the request misses.
  assign hit = valid[req_idx] && (tag_arr[req_idx] == req_tag) && !bus.in_invalidate;

  always_comb begin
    state_nxt     = state;
    valid_nxt     = valid;
    pend_inv_nxt  = pend_inv;
    out_valid_nxt = 1'b0;
    out_instr_nxt = out_instr;
    mem_req_nxt   = 1'b0;
    mem_addr_nxt  = mem_addr;
    capture       = 1'b0;
    fill_write    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_invalidate) valid_nxt = '0;
        if (bus.in_req_read_req) begin
          if (hit) begin
            out_valid_nxt = 1'b1;
            out_instr_nxt = data_arr[req_idx][req_off];
          end else begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = {req_tag, req_idx, {(OFF_BITS+BYTE_BITS){1'b0}}};
            capture      = 1'b1;
            pend_inv_nxt = 1'b0;
            state_nxt    = WAIT_FOR_MEM;
          end
        end
      end
      WAIT_FOR_MEM: begin
        if (bus.in_invalidate) begin
          valid_nxt    = '0;
          pend_inv_nxt = 1'b1;
        end
        if (bus.in_mem_access_valid) begin
          fill_write = 1'b1;
          // Data requested before an invalidate is stored but never trusted.
          valid_nxt[cap_idx] = !(pend_inv || bus.in_invalidate);
          pend_inv_nxt  = 1'b0;
          out_valid_nxt = 1'b1;
          out_instr_nxt = fill_line[cap_off];
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      pend_inv  <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state     <= state_nxt;
      valid     <= valid_nxt;
      pend_inv  <= pend_inv_nxt;
      out_valid <= out_valid_nxt;
      out_instr <= out_instr_nxt;
      mem_req   <= mem_req_nxt;
      mem_addr  <= mem_addr_nxt;
    end
  end

  // Tag/data storage and the captured miss address carry no reset; the
  // valid bits alone decide whether their contents are used.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_tag <= req_tag;
      cap_idx <= req_idx;
      cap_off <= req_off;
    end
    if (fill_write) begin
      data_arr[cap_idx] <= fill_line;
      tag_arr[cap_idx]  <= cap_tag;
    end
  end

  assign bus.out_req_read_valid  = out_valid;
  assign bus.out_req_read_instr  = out_instr;
  assign bus.out_mem_access_req  = mem_req;
  assign bus.out_mem_access_addr = mem_addr;
endmodule

// File: doc/snow64_direct_mapped_instr_cache.md
Name: snow64_direct_mapped_instr_cache

Overview:
Parametrised direct-mapped, read-only instruction cache with NUM_LINES lines, each holding LINE_WIDTH bits. It sits between the fetch stage and the memory arbiter, and is the drop-in successor of the single-line fake instruction cache. Ports are the same ReqRead/MemAccess pair, plus whole-cache invalidate, async active-low reset and line-aligned fill requests.

Parameters:
ADDR_WIDTH, 64, CPU byte-address width.
INSTR_WIDTH, 32, instruction width in bits (power of 2, >= 8).
LINE_WIDTH, 256, line width in bits (power-of-2 multiple of INSTR_WIDTH).
NUM_LINES, 8, line count (power of 2, >= 2).
Derived:
- BYTE_BITS = log2(INSTR_WIDTH/8)
- OFF_BITS = log2(LINE_WIDTH/INSTR_WIDTH)
- IDX_BITS = log2(NUM_LINES)
- TAG_BITS = ADDR_WIDTH - IDX_BITS - OFF_BITS - BYTE_BITS

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  reset; asynchronous, active-low.
in_req_read_req  in  1  fetch request, sampled each posedge.
in_req_read_addr  in  ADDR_WIDTH  fetch byte address; low BYTE_BITS ignored.
in_invalidate  in  1  clear all line valid bits.
out_req_read_valid  out  1  out_req_read_instr valid this cycle.
out_req_read_instr  out  INSTR_WIDTH  fetched instruction.
out_mem_access_req  out  1  one-cycle fill request pulse.
out_mem_access_addr  out  ADDR_WIDTH  line-aligned fill address (low OFF_BITS+BYTE_BITS zero).
in_mem_access_valid  in  1  fill data valid.
in_mem_access_data  in  LINE_WIDTH  fill line; instruction k at bits [k*INSTR_WIDTH +: INSTR_WIDTH].

Behaviour:
Address split, MSB to LSB: tag | index | offset | byte.
Reset (rst_n=0, async):
- state=IDLE; all valid bits, out_req_read_valid, out_req_read_instr, out_mem_access_req, out_mem_access_addr = 0; pending-invalidate flag = 0.
- Data/tag arrays need no reset.
- Reset mid-miss abandons the fill; an in_mem_access_valid arriving afterwards in IDLE is ignored.
IDLE:
- in_invalidate=1: clear all valid bits. A same-cycle req is evaluated against the cleared state, so it always misses.
- req and hit (valid[idx] and tag match): next cycle out_req_read_valid=1, instr=line[idx][off]; 1-cycle latency; back-to-back hits every cycle.
- req and miss: next cycle out_req_read_valid=0, out_mem_access_req=1 for exactly one cycle, out_mem_access_addr=aligned addr. Capture tag, idx and off; go to WAIT_FOR_MEM.
- no req: out_req_read_valid=0 next cycle; out_req_read_instr holds its last value.
WAIT_FOR_MEM:
- out_mem_access_req=0.
- in_req_read_req and addr are ignored; the requester holds them stable until valid.
- in_invalidate=1 sets the pending-invalidate flag and clears all valid bits.
- in_mem_access_valid=1: write data and tag into the captured idx. Set valid[idx]=1 only if pending-invalidate=0 (data fetched before an invalidate is not trusted); clear the flag. Next cycle out_req_read_valid=1 with instr=data[captured off]; return to IDLE.
- Fill and invalidate in the same cycle: the line is written but left invalid.
- After a fill, a request to the same line hits on the next request cycle, including the first cycle back in IDLE.
Conflicts:
- Conflict misses evict unconditionally; there is no replacement choice.
- No write path.
- Address wrap at 2^ADDR_WIDTH is natural (tag/index arithmetic only).

Test Plan:
1. Default params, post-reset, req addr 0x100 -> miss; out_mem_access_req pulse, addr 0x100, valid=0. Data with word k = 0xA000_0000+k one cycle later -> next cycle valid=1, instr 0xA0000000.
2. After (1), reqs 0x104, 0x11C, 0x102 on consecutive cycles -> 3 hits, instrs 0xA0000001, 0xA0000007, 0xA0000000 (byte bits ignored), no mem req.
3. Fill 0x100 then miss 0x200 (same index 0, new tag) -> fill addr 0x200; later req 0x100 misses again (evicted).
4. Fill lines 0x100 and 0x120, assert in_invalidate, then req 0x120 -> miss, mem req addr 0x120.
5. Miss on 0x140, pulse in_invalidate during WAIT, deliver fill -> instr returned with valid=1; immediate re-req 0x140 misses again.
6. Miss on 0x160, drop rst_n for 1 cycle before fill, then raise in_mem_access_valid -> outputs stay 0, no valid asserted; next req 0x160 issues a fresh mem request.
